next_line_prefetcher: RTL and testbench
=======================================

NEXT_LINE_PREFETCHER -- requirements
Module: next_line_prefetcher

Interface
REQ-001 SHALL have parameter s_offset, default 5, meaning byte-offset bits per cacheline (32-byte line).
REQ-002 SHALL have parameter s_line, default 256, meaning cacheline width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port prefetch_start  input  1  cache reports demand miss; one-cycle pulse.
REQ-006 SHALL have port cacheline_address  input  32  line address of demand miss.
REQ-007 SHALL have port cache_way  input  1  way to be filled with prefetched line.
REQ-008 SHALL have port pmem_busy  input  1  demand traffic owns physical memory port.
REQ-009 SHALL have port pf_pmem_read  output  1  prefetch line read request to memory.
REQ-010 SHALL have port pf_pmem_address  output  32  line-aligned prefetch address.
REQ-011 SHALL have port pf_pmem_rdata  input  256  line data from memory.
REQ-012 SHALL have port pf_pmem_resp  input  1  memory read done; rdata valid this cycle.
REQ-013 SHALL have port prefetch_rdata  output  256  buffered prefetched line.
REQ-014 SHALL have port prefetch_ready  output  1  buffered line valid for cache.
REQ-015 SHALL have port pf_cline_address  output  32  address of buffered line.
REQ-016 SHALL have port pf_cache_way  output  1  way for buffered line.
REQ-017 SHALL have port prefetch_ack  input  1  cache consumed buffered line this cycle.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, READY.
REQ-019 IDLE + prefetch_start: SHALL latch target = {cacheline_address[31:5]+1, 5'b0} and cache_way, go ISSUE next cycle.
REQ-020 Target wrap: if cacheline_address[31:5] is all ones, SHALL drop request, remain IDLE, no memory read.
REQ-021 ISSUE: SHALL hold pf_pmem_read=0 while pmem_busy=1; when pmem_busy=0 go WAIT.
REQ-022 WAIT: SHALL assert pf_pmem_read=1 and pf_pmem_address=target every cycle until pf_pmem_resp=1; pmem_busy ignored once in WAIT.
REQ-023 WAIT + pf_pmem_resp: SHALL capture pf_pmem_rdata into line buffer, drop pf_pmem_read next cycle, go READY.
REQ-024 READY: SHALL assert prefetch_ready=1 with prefetch_rdata, pf_cline_address, pf_cache_way stable until prefetch_ack=1, then go IDLE next cycle.
REQ-025 Minimum latency start->prefetch_ready: 3 cycles with pmem_busy=0 and resp in first WAIT cycle.
REQ-026 prefetch_ack outside READY SHALL be ignored.
REQ-027 prefetch_start in ISSUE/WAIT/READY SHALL be dropped (see REQ-032 for macro override).
REQ-028 prefetch_start and prefetch_ack same cycle in READY: ack completes, start handled per REQ-027/REQ-032.
REQ-029 pf_pmem_address SHALL equal target in all states; pf_pmem_read SHALL be 1 only in WAIT.

Reset
REQ-030 rst=0 SHALL immediately force IDLE; pf_pmem_read=0, prefetch_ready=0, pf_pmem_address=0, pf_cline_address=0, pf_cache_way=0, prefetch_rdata=0, pending slot empty.
REQ-031 Reset during WAIT SHALL abandon the read; a later pf_pmem_resp with no outstanding read SHALL be ignored.

Configuration
REQ-032 Macro PREFETCH_PENDING_EN defined: one-entry pending slot SHALL capture prefetch_start (address, way) arriving outside IDLE, newest overwriting older; on entering IDLE with slot full, SHALL launch it next cycle as in REQ-019 and clear slot.
REQ-033 Macro PREFETCH_PENDING_EN undefined: no pending slot; REQ-027 applies unmodified.

Structure
REQ-034 Package prefetch_pkg SHALL hold state enum pf_state_t, LINE_BYTES, LINE_BITS, and address-to-next-line helper constants.
REQ-035 Line buffer (data, address, way, valid) SHALL be sub-module pf_line_buffer; FSM in top module.

Verification
REQ-036 Start addr 0x0000_1040 way 1, busy=0, resp after 2 WAIT cycles -> pf_pmem_address 0x0000_1060, ready with rdata, pf_cache_way 1, held until ack.
REQ-037 Start addr 0xFFFF_FFE0 -> no pf_pmem_read ever, stays IDLE.
REQ-038 pmem_busy=1 for 5 cycles after start -> pf_pmem_read stays 0 those cycles, asserts the cycle after busy falls.
REQ-039 Second start (addr 0x2000) during WAIT -> macro off: dropped; macro on: after ack, read of 0x2020 issued.
REQ-040 rst=0 mid-WAIT, then stray pf_pmem_resp -> all outputs 0, prefetch_ready never asserts.

Source files
------------

// File: rtl/prefetch_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_pkg
// Shared definitions for the next-line prefetcher:
//   pf_state_t   - prefetch FSM state encoding (IDLE, ISSUE, WAIT, READY)
//   LINE_BYTES   - bytes per cacheline
//   LINE_BITS    - bits per cacheline
//   ADDR_W       - byte-address width
//   OFFSET_BITS  - byte-offset bits within a line
//   LINE_NUM_W   - width of the line number (address without the offset)
//   LINE_NUM_LAST- highest line number; its successor would wrap to zero
// -----------------------------------------------------------------------------
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    READY = 2'd3
  } pf_state_t;

  localparam int LINE_BYTES  = 32;
  localparam int LINE_BITS   = LINE_BYTES * 8;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int LINE_NUM_W  = ADDR_W - OFFSET_BITS;

  localparam logic [LINE_NUM_W-1:0] LINE_NUM_LAST = '1;

endpackage

// File: rtl/pf_line_buffer.sv
// -----------------------------------------------------------------------------
// pf_line_buffer
// Holds one prefetched cacheline together with its address and target way
// until the cache consumes it.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset; empties the buffer and zeroes it
//   i_load   - capture i_data/i_addr/i_way and mark the buffer valid
//   i_clear  - cache consumed the line; mark the buffer empty
//   i_data   - line data to capture
//   i_addr   - line-aligned address of the line being captured
//   i_way    - cache way the line is destined for
//   o_data   - buffered line data
//   o_addr   - buffered line address
//   o_way    - buffered line way
//   o_valid  - buffer holds a line the cache has not yet consumed
// -----------------------------------------------------------------------------
module pf_line_buffer #(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [s_line-1:0] i_data,
  input  logic [31:0]       i_addr,
  input  logic              i_way,
  output logic [s_line-1:0] o_data,
  output logic [31:0]       o_addr,
  output logic              o_way,
  output logic              o_valid
);

  logic [s_line-1:0] r_data;
  logic [31:0]       r_addr;
  logic              r_way;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_addr  <= '0;
      r_way   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_addr  <= i_addr;
      r_way   <= i_way;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      // Contents are left in place; only validity is withdrawn.
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_addr  = r_addr;
  assign o_way   = r_way;
  assign o_valid = r_valid;

endmodule

// File: rtl/next_line_prefetcher.sv
// -----------------------------------------------------------------------------
// next_line_prefetcher
// On a demand miss, fetches the following cacheline from memory into a
// one-line buffer and offers it to the cache until acknowledged.
//
// Optional feature: define PREFETCH_PENDING_EN to add a one-entry pending slot
// that remembers the newest miss arriving while a prefetch is in flight and
// launches it as soon as the FSM returns to IDLE. Without the macro such
// misses are dropped.
//
// Ports:
//   clk               - clock, rising edge
//   rst               - asynchronous active-low reset
//   prefetch_start    - demand-miss pulse from the cache
//   cacheline_address - address of the missing line
//   cache_way         - way the prefetched line should fill
//   pmem_busy         - demand traffic currently owns the memory port
//   pf_pmem_read      - prefetch read request (high only while waiting)
//   pf_pmem_address   - line-aligned prefetch target address
//   pf_pmem_rdata     - line data from memory
//   pf_pmem_resp      - memory read complete, rdata valid this cycle
//   prefetch_rdata    - buffered prefetched line
//   prefetch_ready    - buffered line is valid for the cache
//   pf_cline_address  - address of the buffered line
//   pf_cache_way      - way of the buffered line
//   prefetch_ack      - cache consumed the buffered line this cycle
// -----------------------------------------------------------------------------
module next_line_prefetcher
  import prefetch_pkg::*;
#(
  parameter int s_offset = OFFSET_BITS,
  parameter int s_line   = LINE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prefetch_start,
  input  logic [31:0]       cacheline_address,
  input  logic              cache_way,
  input  logic              pmem_busy,
  output logic              pf_pmem_read,
  output logic [31:0]       pf_pmem_address,
  input  logic [s_line-1:0] pf_pmem_rdata,
  input  logic              pf_pmem_resp,
  output logic [s_line-1:0] prefetch_rdata,
  output logic              prefetch_ready,
  output logic [31:0]       pf_cline_address,
  output logic              pf_cache_way,
  input  logic              prefetch_ack
);

  localparam int LN_W = ADDR_W - s_offset;

  pf_state_t       r_state;
  logic [31:0]     r_target;
  logic            r_way;

  logic            w_req_valid;
  logic [LN_W-1:0] w_req_line;
  logic            w_req_way;
  logic            w_launch;
  logic [31:0]     w_next_target;
  logic            w_load;
  logic            w_clear;
  logic            w_unused_offset;

  // The byte offset of the miss address never influences the next line.
  assign w_unused_offset = ^cacheline_address[s_offset-1:0];

`ifdef PREFETCH_PENDING_EN
  logic            r_slot_valid;
  logic [LN_W-1:0] r_slot_line;
  logic            r_slot_way;

  // A live start in IDLE is the newest request and supersedes the slot.
  always_comb begin
    w_req_valid = prefetch_start | r_slot_valid;
    w_req_line  = r_slot_line;
    w_req_way   = r_slot_way;
    if (prefetch_start) begin
      w_req_line = cacheline_address[31:s_offset];
      w_req_way  = cache_way;
    end
  end

  // Busy: remember the newest miss. Idle: whatever the slot held is consumed
  // this cycle (launched, overridden, or dropped because it would wrap).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_valid <= 1'b0;
      r_slot_line  <= '0;
      r_slot_way   <= 1'b0;
    end else if (r_state != IDLE) begin
      if (prefetch_start) begin
        r_slot_valid <= 1'b1;
        r_slot_line  <= cacheline_address[31:s_offset];
        r_slot_way   <= cache_way;
      end
    end else begin
      r_slot_valid <= 1'b0;
    end
  end
`else
  assign w_req_valid = prefetch_start;
  assign w_req_line  = cacheline_address[31:s_offset];
  assign w_req_way   = cache_way;
`endif

  // The last line of the address space has no successor; such requests die.
  assign w_launch      = (r_state == IDLE) && w_req_valid && !(&w_req_line);
  assign w_next_target = {w_req_line + LN_W'(1), {s_offset{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_way    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_target <= w_next_target;
            r_way    <= w_req_way;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!pmem_busy) r_state <= WAIT;
        end
        // Once the read is on the bus it is held regardless of pmem_busy.
        WAIT: begin
          if (pf_pmem_resp) r_state <= READY;
        end
        READY: begin
          if (prefetch_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A response outside WAIT has no outstanding read behind it and is ignored.
  assign w_load  = (r_state == WAIT) && pf_pmem_resp;
  assign w_clear = (r_state == READY) && prefetch_ack;

  pf_line_buffer #(
    .s_line (s_line)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_data  (pf_pmem_rdata),
    .i_addr  (r_target),
    .i_way   (r_way),
    .o_data  (prefetch_rdata),
    .o_addr  (pf_cline_address),
    .o_way   (pf_cache_way),
    .o_valid (prefetch_ready)
  );

  assign pf_pmem_read    = (r_state == WAIT);
  assign pf_pmem_address = r_target;

endmodule

// File: tb/tb_next_line_prefetcher.sv
// -----------------------------------------------------------------------------
// tb_next_line_prefetcher
// Directed stimulus for next_line_prefetcher. The stimulus process pushes the
// expected memory reads and expected ready lines into queues; a monitor on the
// falling edge pops and compares whenever the DUT raises pf_pmem_read or
// prefetch_ready, and checks that both stay stable while asserted.
// -----------------------------------------------------------------------------
module tb_next_line_prefetcher;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         prefetch_start = 1'b0;
  logic [31:0]  cacheline_address = '0;
  logic         cache_way = 1'b0;
  logic         pmem_busy = 1'b0;
  logic         pf_pmem_read;
  logic [31:0]  pf_pmem_address;
  logic [255:0] pf_pmem_rdata = '0;
  logic         pf_pmem_resp = 1'b0;
  logic [255:0] prefetch_rdata;
  logic         prefetch_ready;
  logic [31:0]  pf_cline_address;
  logic         pf_cache_way;
  logic         prefetch_ack = 1'b0;

  next_line_prefetcher dut (
    .clk               (clk),
    .rst               (rst),
    .prefetch_start    (prefetch_start),
    .cacheline_address (cacheline_address),
    .cache_way         (cache_way),
    .pmem_busy         (pmem_busy),
    .pf_pmem_read      (pf_pmem_read),
    .pf_pmem_address   (pf_pmem_address),
    .pf_pmem_rdata     (pf_pmem_rdata),
    .pf_pmem_resp      (pf_pmem_resp),
    .prefetch_rdata    (prefetch_rdata),
    .prefetch_ready    (prefetch_ready),
    .pf_cline_address  (pf_cline_address),
    .pf_cache_way      (pf_cache_way),
    .prefetch_ack      (prefetch_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         way;
    int           cycle;
  } exp_t;

  exp_t rd_q[$];
  exp_t rdy_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_rd  = 1'b0;
  logic prev_rdy = 1'b0;
  exp_t mon_e;
  exp_t held_rd;
  exp_t held_rdy;

  always @(negedge clk) begin
    if (pf_pmem_read && !prev_rd) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got address %0h, expected no read (cycle %0d)",
                 pf_pmem_address, cyc);
      end else begin
        mon_e = rd_q.pop_front();
        chk("rd_addr", pf_pmem_address, mon_e.addr);
        chk("rd_cycle", cyc, mon_e.cycle);
        held_rd <= mon_e;
      end
    end else if (pf_pmem_read && prev_rd) begin
      chk("rd_addr_hold", pf_pmem_address, held_rd.addr);
    end

    if (prefetch_ready && !prev_rdy) begin
      if (rdy_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got address %0h, expected no ready (cycle %0d)",
                 pf_cline_address, cyc);
      end else begin
        mon_e = rdy_q.pop_front();
        chk("rdy_data", prefetch_rdata, mon_e.data);
        chk("rdy_addr", pf_cline_address, mon_e.addr);
        chk("rdy_way", pf_cache_way, mon_e.way);
        chk("rdy_cycle", cyc, mon_e.cycle);
        held_rdy <= mon_e;
      end
    end else if (prefetch_ready && prev_rdy) begin
      chk("rdy_data_hold", prefetch_rdata, held_rdy.data);
      chk("rdy_addr_hold", pf_cline_address, held_rdy.addr);
      chk("rdy_way_hold", pf_cache_way, held_rdy.way);
    end

    prev_rd  <= pf_pmem_read;
    prev_rdy <= prefetch_ready;
  end

  task automatic push_rd(input logic [31:0] a, input int c);
    exp_t e;
    e.addr = a; e.data = '0; e.way = 1'b0; e.cycle = c;
    rd_q.push_back(e);
  endtask

  task automatic push_rdy(input logic [31:0] a, input logic [255:0] d, input logic w, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.way = w; e.cycle = c;
    rdy_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"},  pf_pmem_read, 0);
    chk({tag, "_ready"}, prefetch_ready, 0);
    chk({tag, "_paddr"}, pf_pmem_address, 0);
    chk({tag, "_caddr"}, pf_cline_address, 0);
    chk({tag, "_way"},   pf_cache_way, 0);
    chk({tag, "_rdata"}, prefetch_rdata, 0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
  localparam logic [255:0] D3 = {8{32'h3C3C_0003}};
  localparam logic [255:0] D4 = {8{32'h1234_0004}};
  localparam logic [255:0] D5 = {8{32'hCAFE_0005}};
  localparam logic [255:0] D6 = {8{32'hDEAD_0006}};

  int s;

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    // Basic prefetch: 0x1040 way 1, response after two quiet WAIT cycles
    prefetch_start = 1'b1; cacheline_address = 32'h0000_1040; cache_way = 1'b1;
    tick(); s = cyc;
    prefetch_start = 1'b0; cacheline_address = '0; cache_way = 1'b0;
    push_rd(32'h0000_1060, s + 1);
    push_rdy(32'h0000_1060, D1, 1'b1, s + 4);
    prefetch_ack = 1'b1;                 // ack in ISSUE must be ignored
    tick();                              // s+1 WAIT
    prefetch_ack = 1'b0;
    tick();                              // s+2 WAIT
    tick();                              // s+3 WAIT, respond
    pf_pmem_resp = 1'b1; pf_pmem_rdata = D1;
    tick();                              // s+4 READY
    pf_pmem_resp = 1'b0; pf_pmem_rdata = '0;
    chk("t1_rd_drop", pf_pmem_read, 0);
    tick(); tick();                      // held through s+5, s+6
    prefetch_ack = 1'b1;
    tick();
    prefetch_ack = 1'b0;
    chk("t1_ready_drop", prefetch_ready, 0);

    // Last line of the address space: no successor, request dropped
    prefetch_start = 1'b1; cacheline_address = 32'hFFFF_FFE0; cache_way = 1'b1;
    tick();
    prefetch_start = 1'b0; cacheline_address = '0; cache_way = 1'b0;
    repeat (5) tick();
    chk("t2_no_read", pf_pmem_read, 0);
    chk("t2_target_kept", pf_pmem_address, 32'h0000_1060);

    // Memory busy for five cycles after the start
    pmem_busy = 1'b1;
    prefetch_start = 1'b1; cacheline_address = 32'h0000_3000; cache_way = 1'b0;
    tick(); s = cyc;
    prefetch_start = 1'b0; cacheline_address = '0;
    push_rd(32'h0000_3020, s + 6);
    repeat (5) tick();                   // now in s+5
    pmem_busy = 1'b0;
    tick();                              // s+6 WAIT
    pmem_busy = 1'b1;                    // ignored once waiting
    pf_pmem_resp = 1'b1; pf_pmem_rdata = D3;
    push_rdy(32'h0000_3020, D3, 1'b0, s + 7);
    tick();                              // s+7 READY
    pmem_busy = 1'b0; pf_pmem_resp = 1'b0; pf_pmem_rdata = '0;
    prefetch_ack = 1'b1;
    tick();
    prefetch_ack = 1'b0;
    chk("t3_ready_drop", prefetch_ready, 0);

    // Second start during WAIT
    prefetch_start = 1'b1; cacheline_address = 32'h0000_1000; cache_way = 1'b0;
    tick(); s = cyc;
    prefetch_start = 1'b0; cacheline_address = '0;
    push_rd(32'h0000_1020, s + 1);
    tick();                              // s+1 WAIT
    prefetch_start = 1'b1; cacheline_address = 32'h0000_2000; cache_way = 1'b1;
    tick();                              // s+2 WAIT
    prefetch_start = 1'b0; cacheline_address = '0; cache_way = 1'b0;
    pf_pmem_resp = 1'b1; pf_pmem_rdata = D4;
    push_rdy(32'h0000_1020, D4, 1'b0, s + 3);
    tick();                              // s+3 READY
    pf_pmem_resp = 1'b0; pf_pmem_rdata = '0;
    prefetch_ack = 1'b1;
`ifdef PREFETCH_PENDING_EN
    push_rd(32'h0000_2020, s + 6);
`endif
    tick();                              // s+4 IDLE
    prefetch_ack = 1'b0;
    chk("t4_ready_drop", prefetch_ready, 0);
`ifdef PREFETCH_PENDING_EN
    tick();                              // s+5 ISSUE
    tick();                              // s+6 WAIT
    pf_pmem_resp = 1'b1; pf_pmem_rdata = D5;
    push_rdy(32'h0000_2020, D5, 1'b1, s + 7);
    tick();                              // s+7 READY
    pf_pmem_resp = 1'b0; pf_pmem_rdata = '0;
    prefetch_ack = 1'b1;
    tick();
    prefetch_ack = 1'b0;
    chk("t4_pend_ready_drop", prefetch_ready, 0);
`else
    repeat (6) tick();
    chk("t4_no_read", pf_pmem_read, 0);
    chk("t4_target_kept", pf_pmem_address, 32'h0000_1020);
`endif

    // Reset in the middle of WAIT, then a stray response
    prefetch_start = 1'b1; cacheline_address = 32'h0000_4000; cache_way = 1'b1;
    tick();
    prefetch_start = 1'b0; cacheline_address = '0; cache_way = 1'b0;
    tick();                              // WAIT
    chk("t5_wait_read", pf_pmem_read, 1);
    chk("t5_wait_addr", pf_pmem_address, 32'h0000_4020);
    #2 rst = 1'b0;
    #1 chk_all_zero("t5_async");
    tick();
    rst = 1'b1;
    tick();
    pf_pmem_resp = 1'b1; pf_pmem_rdata = D6;
    tick();
    pf_pmem_resp = 1'b0; pf_pmem_rdata = '0;
    repeat (4) tick();
    chk_all_zero("t5_after");

    // Every expected event must have been observed
    chk("rd_events_left", rd_q.size(), 0);
    chk("rdy_events_left", rdy_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
